mtm_alu_ctrl: RTL and testbench
===============================

Name: mtm_alu_ctrl

Overview:
- Sequencing controller between mtm_Alu_deserializer, mtm_Alu_core and mtm_Alu_serializer.
- Accepts one decoded request (A, B, opcode, error flags) per transaction and holds the core operands stable for the core latency.
- Derives result flags from the core result, computes the response CRC3, and hands a packed response (32-bit data + 8-bit control) to the serializer over a valid/ready handshake.
- Illegal opcodes and deserializer errors become error frames without exercising the core.

Parameters:
- CORE_LAT, 1: cycles from stable core operands to valid core_c/core_carry; legal range 1..4.

Ports:
- clk  in  1  posedge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request strobe from deserializer
- in_ready  out  1  controller can accept a request
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_op  in  3  opcode
- in_err_data  in  1  deserializer framing/data error
- in_err_crc  in  1  deserializer request CRC mismatch
- core_a  out  32  registered operand A to core
- core_b  out  32  registered operand B to core
- core_op  out  3  registered opcode to core
- core_c  in  32  core result
- core_carry  in  1  core carry/borrow
- out_valid  out  1  response available to serializer
- out_ready  in  1  serializer accepts response
- out_data  out  32  response data word (0 for error frames)
- out_ctl  out  8  response control byte

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ctl=0, core_a/core_b=0, core_op=3'b000.
  - Reset mid-transaction abandons the transaction with no frame emitted.
- Opcodes: AND=000, OR=001, ADD=100, SUB=101 (SUB result is B−A). Any other value is illegal (ERR_OP).
- States:
  - IDLE: in_ready=1. On in_valid, capture all inputs.
    - If any error: go to PACK with err set.
    - Otherwise: go to EXEC and load core_a/core_b/core_op.
  - EXEC: in_ready=0. Counter runs CORE_LAT cycles, then samples core_c/core_carry and goes to PACK.
  - PACK: one cycle. Compute flags, CRC3 or parity; load out_data/out_ctl; go to SEND.
  - SEND: out_valid=1, with out_data/out_ctl held stable until out_valid & out_ready. Then out_valid=0 and go to IDLE.
- in_ready is 1 only in IDLE. in_valid in other states is ignored; the deserializer must hold off.
- Latency:
  - Normal frame: out_valid rises CORE_LAT+2 edges after the capture edge.
  - Error frame: out_valid rises 2 edges after the capture edge.
  - Back-to-back throughput with out_ready=1: one transaction per CORE_LAT+4 cycles.
- Flags {C,V,Z,N}:
  - C = core_carry, for ADD/SUB only, else 0.
  - V = signed overflow, for ADD/SUB only, else 0.
    - ADD: V = (A[31]==B[31]) & (res[31]!=A[31]).
    - SUB: V = (B[31]!=A[31]) & (res[31]!=B[31]).
  - Z = (res==0).
  - N = res[31].
- Normal ctl byte = {1'b0, C, V, Z, N, crc3}.
  - crc3 uses polynomial x^3+x+1, init 3'b000, over 37 bits {res[31:0], 1'b0, C, V, Z, N}, MSB first.
- Error ctl byte = {1'b1, ed, ec, eo, ed, ec, eo, p}.
  - p is even parity over bits [7:1].
  - Exactly one error bit is set; priority ERR_DATA > ERR_CRC > ERR_OP.
  - Illegal opcode with in_err_crc=1 reports ERR_CRC only.
- out_ready high before SEND has no effect.
- out_ready low in SEND stalls indefinitely with outputs stable; the core is not re-driven.

Decomposition:
- Package mtm_alu_pkg:
  - opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB);
  - state enum (IDLE, EXEC, PACK, SEND);
  - error-index constants;
  - function crc3_37 (pure combinational, shared with the serializer checker);
  - function is_legal_op.
- Sub-module mtm_alu_ctrl_pack: combinational flag derivation plus ctl-byte formation (normal/error). The FSM and registers stay in mtm_alu_ctrl.

Test Plan:
- ADD A=0xFFFFFFFF, B=0x00000001, core_c=0, carry=1 -> out_data=0x00000000, flags CVZN=1010, crc3=crc3_37, out_valid at capture+CORE_LAT+2.
- ADD A=0x7FFFFFFF, B=0x00000001 -> out_data=0x80000000, CVZN=0101.
- SUB A=1, B=0, core_c=0xFFFFFFFF, carry=1 -> CVZN=1001.
- AND with the AND core result -> CVZN per Z/N only, C=V=0.
- Error frames:
  - in_op=3'b111 -> out_ctl=0x93, out_data=0.
  - in_err_data=1 -> out_ctl=0xC9.
  - in_err_crc=1 with op=3'b111 -> out_ctl=0xA5.
  - In all three: core_a/core_b/core_op unchanged.
- Stalls and reset:
  - out_ready=0 for 10 cycles in SEND -> out_valid/out_data/out_ctl stable and in_ready=0; single accept on release, then in_ready=1 next cycle.
  - rst=1 during EXEC -> next cycle all outputs at reset values, no frame emitted.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the ALU controller: opcodes, FSM states,
// error-bit positions and the response CRC3.
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, PACK, SEND} state_e;

  // Bit positions inside the {ed, ec, eo} error triple.
  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  // CRC3, polynomial x^3+x+1, init 0, MSB first over 37 bits.
  function automatic logic [2:0] crc3_37(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_ctrl_pack.sv
// Combinational response formation: flags, CRC3 and the control byte
// for normal frames, one-hot error code plus parity for error frames.
module mtm_alu_ctrl_pack
  import mtm_alu_pkg::*;
(
  input  logic        a_msb,
  input  logic        b_msb,
  input  logic [31:0] res,
  input  logic        carry,
  input  logic [2:0]  op,
  input  logic [2:0]  err,    // {ed, ec, eo}, at most one bit set
  output logic [31:0] data,
  output logic [7:0]  ctl
);

  logic arith, c, v, z, n;
  logic [6:0] ectl;

  // Flag derivation and frame selection.
  always_comb begin
    arith = (op == OP_ADD) || (op == OP_SUB);
    c     = arith & carry;
    v     = 1'b0;
    if (op == OP_ADD) v = (a_msb == b_msb) & (res[31] != a_msb);
    if (op == OP_SUB) v = (b_msb != a_msb) & (res[31] != b_msb);
    z     = (res == 32'd0);
    n     = res[31];
    ectl  = {1'b1, err, err};
    if (|err) begin
      data = 32'd0;
      ctl  = {ectl, ^ectl};   // even parity over bits [7:1]
    end else begin
      data = res;
      ctl  = {1'b0, c, v, z, n, crc3_37({res, 1'b0, c, v, z, n})};
    end
  end

endmodule

// File: rtl/mtm_alu_ctrl.sv
// Sequencing controller: captures a decoded request, drives the core for
// CORE_LAT cycles, packs the response and hands it to the serializer.
module mtm_alu_ctrl
  import mtm_alu_pkg::*;
#(
  parameter int CORE_LAT = 1   // 1..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  input  logic        in_err_data,
  input  logic        in_err_crc,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic [2:0]  core_op,
  input  logic [31:0] core_c,
  input  logic        core_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_ctl
);

  localparam logic [1:0] CNT_LAST = 2'(CORE_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] core_a_q, core_a_d, core_b_q, core_b_d;
  logic [2:0]  core_op_q, core_op_d;
  logic [2:0]  err_q, err_d, err_in;
  logic [31:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic [31:0] out_data_q, out_data_d, pk_data;
  logic [7:0]  out_ctl_q, out_ctl_d, pk_ctl;
  logic        out_valid_q, out_valid_d;

  // Error frames bypass the core; for those the stale core registers are
  // ignored by the packer because err selects the error byte.
  mtm_alu_ctrl_pack u_pack (
    .a_msb (core_a_q[31]),
    .b_msb (core_b_q[31]),
    .res   (res_q),
    .carry (carry_q),
    .op    (core_op_q),
    .err   (err_q),
    .data  (pk_data),
    .ctl   (pk_ctl)
  );

  // Next-state and datapath loads.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    core_op_d   = core_op_q;
    err_d       = err_q;
    res_d       = res_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_ctl_d   = out_ctl_q;
    out_valid_d = out_valid_q;

    err_in           = 3'b000;
    err_in[ERR_DATA] = in_err_data;
    err_in[ERR_CRC]  = ~in_err_data & in_err_crc;
    err_in[ERR_OP]   = ~in_err_data & ~in_err_crc & ~is_legal_op(in_op);

    case (state_q)
      IDLE: if (in_valid) begin
        err_d = err_in;
        cnt_d = 2'd0;
        if (|err_in) begin
          state_d = PACK;
        end else begin
          core_a_d  = in_a;
          core_b_d  = in_b;
          core_op_d = in_op;
          state_d   = EXEC;
        end
      end
      EXEC: if (cnt_q == CNT_LAST) begin
        res_d   = core_c;
        carry_d = core_carry;
        state_d = PACK;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
      PACK: begin
        out_data_d = pk_data;
        out_ctl_d  = pk_ctl;
        state_d    = SEND;
      end
      SEND: if (out_valid_q & out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end else begin
        out_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      core_a_q    <= 32'd0;
      core_b_q    <= 32'd0;
      core_op_q   <= 3'b000;
      err_q       <= 3'b000;
      res_q       <= 32'd0;
      carry_q     <= 1'b0;
      out_data_q  <= 32'd0;
      out_ctl_q   <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      core_op_q   <= core_op_d;
      err_q       <= err_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_ctl_q   <= out_ctl_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign core_op   = core_op_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ctl   = out_ctl_q;

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Scoreboard bench for mtm_alu_ctrl with a behavioural core of latency 2.
module tb_mtm_alu_ctrl;
  import mtm_alu_pkg::*;

  localparam int CORE_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        in_err_data, in_err_crc;
  logic [31:0] core_a, core_b, core_c;
  logic [2:0]  core_op;
  logic        core_carry;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctl;

  always #5 clk = ~clk;

  mtm_alu_ctrl #(.CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_err_data(in_err_data), .in_err_crc(in_err_crc),
    .core_a(core_a), .core_b(core_b), .core_op(core_op),
    .core_c(core_c), .core_carry(core_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctl(out_ctl)
  );

  // Core model: one register stage, result valid CORE_LAT cycles after operands.
  logic [32:0] core_now, core_r;
  always_comb begin
    case (core_op)
      3'b000:  core_now = {1'b0, core_a & core_b};
      3'b001:  core_now = {1'b0, core_a | core_b};
      3'b100:  core_now = {1'b0, core_a} + {1'b0, core_b};
      3'b101:  core_now = {1'b0, core_b} - {1'b0, core_a};
      default: core_now = 33'd0;
    endcase
  end
  always @(posedge clk) core_r <= core_now;
  assign {core_carry, core_c} = core_r;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // CRC by polynomial long division of msg*x^3 by 1011.
  function automatic logic [2:0] ref_crc(input logic [36:0] d);
    logic [39:0] m;
    m = {d, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
    return m[2:0];
  endfunction

  function automatic logic legal(input logic [2:0] op);
    return op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101;
  endfunction

  function automatic logic [39:0] ref_frame(input logic [31:0] a, b, input logic [2:0] op,
                                            input logic ed, ec);
    logic [32:0] w;
    logic c, v, z, n;
    if (ed) return {32'd0, 8'hC9};
    if (ec) return {32'd0, 8'hA5};
    if (!legal(op)) return {32'd0, 8'h93};
    case (op)
      3'b000:  w = {1'b0, a & b};
      3'b001:  w = {1'b0, a | b};
      3'b100:  w = {1'b0, a} + {1'b0, b};
      default: w = {1'b0, b} - {1'b0, a};
    endcase
    c = op[2] ? w[32] : 1'b0;
    v = 1'b0;
    if (op == 3'b100) v = (a[31] == b[31]) && (w[31] != a[31]);
    if (op == 3'b101) v = (a[31] != b[31]) && (w[31] != b[31]);
    z = (w[31:0] == 0);
    n = w[31];
    return {w[31:0], 1'b0, c, v, z, n, ref_crc({w[31:0], 1'b0, c, v, z, n})};
  endfunction

  typedef struct { logic [39:0] exp; int cap; int lat; } sb_t;
  sb_t sb[$];

  // Output monitor: pops on each accepted frame, also measures latency.
  int   rise_cyc = 0;
  logic ov_prev  = 1'b0;
  always @(negedge clk) begin
    sb_t e;
    if (rst) ov_prev = 1'b0;
    else begin
      if (out_valid && !ov_prev) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("extra_frame", 64'(out_valid), 64'd0);
        else begin
          e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(e.exp[39:8]));
          chk("out_ctl",  64'(out_ctl),  64'(e.exp[7:0]));
          chk("latency",  64'(rise_cyc - e.cap), 64'(e.lat));
        end
      end
      ov_prev = out_valid;
    end
  end

  // Called #1 after a posedge; returns #1 after the capture edge.
  task automatic send(input logic [31:0] a, b, input logic [2:0] op,
                      input logic ed, ec, output int cap);
    sb_t e;
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1; in_a = a; in_b = b; in_op = op; in_err_data = ed; in_err_crc = ec;
    cap   = cyc + 1;
    e.exp = ref_frame(a, b, op, ed, ec);
    e.cap = cap;
    e.lat = (ed || ec || !legal(op)) ? 2 : CORE_LAT + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 0; in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
    in_err_data = 0; in_err_crc = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, cx;
    logic [31:0] sa, sb_, sd;
    logic [2:0]  so;
    logic [7:0]  sc;
    logic [2:0]  ops [4];
    ops = '{3'b000, 3'b001, 3'b100, 3'b101};

    rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0;
    in_err_data = 0; in_err_crc = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_ctl",   64'(out_ctl),   64'd0);
    chk("rst_core_a",    64'(core_a),    64'd0);
    chk("rst_core_b",    64'(core_b),    64'd0);
    chk("rst_core_op",   64'(core_op),   64'd0);
    rst = 0; out_ready = 1;
    @(posedge clk); #1;

    // Directed vectors, back to back.
    send(32'hFFFFFFFF, 32'h00000001, 3'b100, 0, 0, c1);
    send(32'h7FFFFFFF, 32'h00000001, 3'b100, 0, 0, c2);
    chk("throughput", 64'(c2 - c1), 64'(CORE_LAT + 4));
    send(32'h00000001, 32'h00000000, 3'b101, 0, 0, cx);
    send(32'hF0F0F0F0, 32'h8F0F0F0F, 3'b000, 0, 0, cx);
    send(32'h0F0F0F0F, 32'hF0F0F0F0, 3'b000, 0, 0, cx);
    send(32'h00000000, 32'h00000000, 3'b001, 0, 0, cx);
    send(32'h80000000, 32'h7FFFFFFF, 3'b101, 0, 0, cx);
    drain();

    // Random legal traffic.
    for (int i = 0; i < 20; i++)
      send($urandom, $urandom, ops[$urandom_range(0, 3)], 0, 0, cx);
    drain();

    // Error frames must not disturb the core operands.
    sa = core_a; sb_ = core_b; so = core_op;
    send(32'h12345678, 32'h9ABCDEF0, 3'b111, 0, 0, cx);
    send(32'h11111111, 32'h22222222, 3'b100, 1, 0, cx);
    send(32'h33333333, 32'h44444444, 3'b111, 0, 1, cx);
    send(32'h55555555, 32'h66666666, 3'b010, 1, 1, cx);
    drain();
    chk("err_core_a",  64'(core_a),  64'(sa));
    chk("err_core_b",  64'(core_b),  64'(sb_));
    chk("err_core_op", 64'(core_op), 64'(so));

    // Stall in SEND for 10 cycles.
    out_ready = 0;
    send(32'h00000005, 32'h00000007, 3'b100, 0, 0, cx);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    end
    chk("stall_valid_seen", 64'(out_valid), 64'd1);
    sd = out_data; sc = out_ctl;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_valid",    64'(out_valid), 64'd1);
      chk("stall_data",     64'(out_data),  64'(sd));
      chk("stall_ctl",      64'(out_ctl),   64'(sc));
      chk("stall_in_ready", 64'(in_ready),  64'd0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("release_valid",    64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready),  64'd1);
    chk("release_popped",   64'(sb.size()), 64'd0);

    // Reset during EXEC abandons the transaction.
    send(32'hCAFEF00D, 32'h01234567, 3'b100, 0, 0, cx);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sb.delete();
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data",  64'(out_data),  64'd0);
    chk("mid_rst_out_ctl",   64'(out_ctl),   64'd0);
    chk("mid_rst_core_a",    64'(core_a),    64'd0);
    chk("mid_rst_core_b",    64'(core_b),    64'd0);
    chk("mid_rst_core_op",   64'(core_op),   64'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_frame_after_rst", 64'(out_valid), 64'd0);
    end

    // Recovery after reset.
    send(32'h00000003, 32'h00000009, 3'b101, 0, 0, cx);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
